gon_xbus: RTL and testbench
===========================

Name: gon_xbus

Overview:
- Return-direction column bus of the global output network. It gathers words from NUM_OF_COLS column ports onto one output stream.
- At any time, only the column whose col_id[i] equals col_tag may transfer. Each accepted word is stored in a 2-entry FIFO and then offered downstream with the source tag attached.
- Sits between the column-level output controllers and the top-level output buffer. It is the collecting counterpart of the broadcasting GIN X-bus.

Parameters:
- DATA_WIDTH, 64, width of each data word.
- COL_TAG_WIDTH, 4, width of col_tag and of each col_id.
- NUM_OF_COLS, 14, number of column input ports.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- col_tag  input  COL_TAG_WIDTH  column to collect from; driven by the top controller.
- col_id  input  COL_TAG_WIDTH x NUM_OF_COLS (unpacked [0:NUM_OF_COLS-1])  static id of each column.
- data_in  input  DATA_WIDTH x NUM_OF_COLS (unpacked [0:NUM_OF_COLS-1])  per-column data.
- enable_in  input  [0:NUM_OF_COLS-1]  per-column valid.
- ready_out  output  [0:NUM_OF_COLS-1]  per-column ready back to the columns.
- data_out  output  DATA_WIDTH  FIFO head data.
- tag_out  output  COL_TAG_WIDTH  col_tag value captured with the head word.
- enable_out  output  1  FIFO head valid.
- ready_in  input  1  downstream ready.
- multi_match_err  output  1  sticky flag: more than one col_id matched col_tag.

Behaviour:
- Match vector:
  - match[i] = (col_id[i] == col_tag), evaluated combinationally.
  - sel = lowest index i with match[i] = 1. Lowest index wins when several match.
  - No match: all ready_out are 0 and no push occurs.
- Storage: 2-entry FIFO with registers rd_ptr, wr_ptr (1 bit each) and count (2 bits, values 0..2). Each entry holds {data, tag}.
- not_full = (count != 2), taken from the registered count only. A pop in the same cycle does not free a slot for a push.
- ready_out[i] = match[i] && (i == sel) && not_full. ready_out is 0 for every other column.
- push = enable_in[sel] && ready_out[sel].
  - On push: mem[wr_ptr] <= {data_in[sel], col_tag}, and wr_ptr toggles.
- pop = enable_out && ready_in.
  - On pop: rd_ptr toggles.
- enable_out = (count != 0).
- data_out and tag_out = mem[rd_ptr]. Values are don't-care while enable_out = 0, but they must be stable while enable_out = 1 and ready_in = 0.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together (count = 1 only): unchanged, and FIFO order is preserved.
- Latency: a push into an empty FIFO makes enable_out = 1 on the next cycle with that word. No combinational path from enable_in to enable_out.
- Throughput: 1 word per cycle while ready_in = 1 (steady state count = 1).
- Tag change:
  - col_tag may change on any cycle. Selection follows the new value immediately.
  - Words already stored keep the tag captured at push.
  - A column that had enable_in = 1 and lost its match is not accepted. It must hold its data per valid/ready rules.
- Error flag:
  - multi_match_err is set on any cycle where more than one match[i] = 1.
  - It is cleared only by reset.
  - The lowest-index column is still served.
- Reset, synchronous and dominant over push/pop:
  - count = 0, rd_ptr = 0, wr_ptr = 0, multi_match_err = 0.
  - Hence enable_out = 0. ready_out becomes nonzero only once the reset deasserts and a match exists.
  - A reset asserted while words are held discards them. No pop is signalled.
- Upstream rule: columns must not drop enable_in or change data_in until ready_out is seen high.
- Downstream rule: the block meets the same rule for its output; data_out and tag_out are held until the pop.

Test Plan:
1. Single-word collect. col_id[i] = i, col_tag = 5, enable_in[5] = 1, data_in[5] = 64'hA5A5_0000_0000_0005, ready_in = 1. Required: ready_out = only bit 5; next cycle enable_out = 1, data_out = 64'hA5A5_0000_0000_0005, tag_out = 5; count returns to 0 after the pop.
2. Backpressure and full. ready_in = 0 while column 3 streams words 1, 2, 3. Required: words 1 and 2 accepted, then ready_out[3] = 0 with count = 2. With ready_in = 1, the output sequence is 1, 2, 3, and ready_out[3] stays 0 during the cycle of the first pop.
3. Streaming. ready_in = 1 continuously, column 13 sends 20 words 0..19. Required: 20 consecutive enable_out cycles after 1-cycle latency, in order, all with tag_out = 13, and no gaps.
4. Tag switch with a held word. FIFO holds a word from column 2; col_tag switches to 7 while ready_in = 0, and column 7 sends word 64'h7. Required: head keeps tag_out = 2, the second entry has tag_out = 7, and the order is preserved.
5. Mismatch and duplicate ids. col_tag = 15 with no column of id 15: all ready_out = 0 and count unchanged. Then col_id[4] = col_id[9] = 6 and col_tag = 6: only ready_out[4] = 1, multi_match_err = 1 next cycle, and it stays 1 until reset.
6. Reset mid-operation. Assert reset with count = 2. Required: next cycle enable_out = 0 and multi_match_err = 0. After reset is released, the first new push appears alone at the output.

Source files
------------

// File: rtl/gon_xbus.sv
// Return-direction column bus: collects words from the column whose id matches
// col_tag into a 2-entry FIFO and presents them downstream tagged with the source.
module gon_xbus #(
  parameter int DATA_WIDTH    = 64,
  parameter int COL_TAG_WIDTH = 4,
  parameter int NUM_OF_COLS   = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COL_TAG_WIDTH-1:0] col_tag,
  input  logic [COL_TAG_WIDTH-1:0] col_id  [0:NUM_OF_COLS-1],
  input  logic [DATA_WIDTH-1:0]    data_in [0:NUM_OF_COLS-1],
  input  logic [0:NUM_OF_COLS-1]   enable_in,
  output logic [0:NUM_OF_COLS-1]   ready_out,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [COL_TAG_WIDTH-1:0] tag_out,
  output logic                     enable_out,
  input  logic                     ready_in,
  output logic                     multi_match_err
);

  logic [DATA_WIDTH-1:0]    r_mem_data [0:1];
  logic [COL_TAG_WIDTH-1:0] r_mem_tag  [0:1];
  logic                     r_rd_ptr;
  logic                     r_wr_ptr;
  logic [1:0]               r_count;
  logic                     r_multi_err;

  logic                     w_found;
  logic                     w_multi;
  logic                     w_sel_en;
  logic [DATA_WIDTH-1:0]    w_sel_data;
  logic [0:NUM_OF_COLS-1]   w_sel_onehot;
  logic                     w_not_full;
  logic                     w_push;
  logic                     w_pop;

  // Priority scan: the first matching column is served, any later match flags an error.
  always_comb begin
    w_found      = 1'b0;
    w_multi      = 1'b0;
    w_sel_en     = 1'b0;
    w_sel_data   = '0;
    w_sel_onehot = '0;
    for (int i = 0; i < NUM_OF_COLS; i++) begin
      if (col_id[i] == col_tag) begin
        if (w_found) begin
          w_multi = 1'b1;
        end else begin
          w_found         = 1'b1;
          w_sel_onehot[i] = 1'b1;
          w_sel_en        = enable_in[i];
          w_sel_data      = data_in[i];
        end
      end
    end
  end

  // Fullness comes from the registered count only, so a same-cycle pop never frees a slot.
  assign w_not_full = (r_count != 2'd2);
  assign ready_out  = (w_not_full && !reset) ? w_sel_onehot : '0;
  assign w_push     = w_found && w_sel_en && w_not_full && !reset;
  assign enable_out = (r_count != 2'd0);
  assign w_pop      = enable_out && ready_in;

  assign data_out        = r_mem_data[r_rd_ptr];
  assign tag_out         = r_mem_tag[r_rd_ptr];
  assign multi_match_err = r_multi_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_multi_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_multi) r_multi_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_sel_data;
      r_mem_tag[r_wr_ptr]  <= col_tag;
    end
  end

endmodule

// File: tb/tb_gon_xbus.sv
// Bench for gon_xbus: directed scenarios plus a randomized run against a queue model.
module tb_gon_xbus;
  localparam int DW = 64;
  localparam int TW = 4;
  localparam int NC = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic [TW-1:0] col_tag;
  logic [TW-1:0] col_id  [0:NC-1];
  logic [DW-1:0] data_in [0:NC-1];
  logic [0:NC-1] enable_in;
  logic [0:NC-1] ready_out;
  logic [DW-1:0] data_out;
  logic [TW-1:0] tag_out;
  logic          enable_out;
  logic          ready_in;
  logic          multi_match_err;

  gon_xbus #(.DATA_WIDTH(DW), .COL_TAG_WIDTH(TW), .NUM_OF_COLS(NC)) dut (
    .clk(clk), .reset(reset), .col_tag(col_tag), .col_id(col_id),
    .data_in(data_in), .enable_in(enable_in), .ready_out(ready_out),
    .data_out(data_out), .tag_out(tag_out), .enable_out(enable_out),
    .ready_in(ready_in), .multi_match_err(multi_match_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } entry_t;

  entry_t q[$];
  logic   m_err;
  int     n_pass = 0;
  int     n_total = 0;

  // Model: which port the spec says may transfer now.
  function automatic logic [0:NC-1] m_ready();
    logic [0:NC-1] r;
    r = '0;
    if (!reset && q.size() < 2) begin
      for (int i = 0; i < NC; i++) begin
        if (col_id[i] == col_tag) begin
          r[i] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic int m_matches();
    int n;
    n = 0;
    for (int i = 0; i < NC; i++) if (col_id[i] == col_tag) n++;
    return n;
  endfunction

  // Advance one clock, updating the model from the inputs driven this cycle.
  task automatic step();
    logic [0:NC-1] rdy;
    bit            push, pop, multi;
    entry_t        e;
    rdy   = m_ready();
    push  = 1'b0;
    e     = '0;
    for (int i = 0; i < NC; i++) begin
      if (rdy[i] && enable_in[i]) begin
        push = 1'b1;
        e    = '{data: data_in[i], tag: col_tag};
      end
    end
    pop   = (q.size() != 0) && ready_in;
    multi = (m_matches() > 1);
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      if (pop)   void'(q.pop_front());
      if (push)  q.push_back(e);
      if (multi) m_err = 1'b1;
    end
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic default_ids();
    for (int i = 0; i < NC; i++) begin
      col_id[i]  = TW'(i);
      data_in[i] = '0;
    end
    enable_in = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; ready_in = 1'b0; col_tag = 4'd0; m_err = 1'b0;
    default_ids();
    step(); step();
    n_total++;
    if (enable_out !== 1'b0) $display("FAIL reset_enable_out: got %b exp 0", enable_out);
    else n_pass++;
    n_total++;
    if (multi_match_err !== 1'b0) $display("FAIL reset_multi_err: got %b exp 0", multi_match_err);
    else n_pass++;
    n_total++;
    if (ready_out !== '0) $display("FAIL reset_ready_out: got %b exp 0", ready_out);
    else n_pass++;
    reset = 1'b0;
    settle();
  endtask

  task automatic test_single();
    logic [0:NC-1] exp;
    exp = '0; exp[5] = 1'b1;
    col_tag = 4'd5; ready_in = 1'b1;
    enable_in[5] = 1'b1; data_in[5] = 64'hA5A5_0000_0000_0005;
    settle();
    n_total++;
    if (ready_out !== exp) $display("FAIL single_ready: got %b exp %b", ready_out, exp);
    else n_pass++;
    step();
    enable_in[5] = 1'b0;
    settle();
    n_total++;
    if (enable_out !== 1'b1 || data_out !== 64'hA5A5_0000_0000_0005 || tag_out !== 4'd5)
      $display("FAIL single_out: got en=%b d=%h t=%0d exp en=1 d=a5a5000000000005 t=5",
               enable_out, data_out, tag_out);
    else n_pass++;
    step();
    n_total++;
    if (enable_out !== 1'b0) $display("FAIL single_drain: got %b exp 0", enable_out);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    col_tag = 4'd3; ready_in = 1'b0;
    for (int w = 1; w <= 2; w++) begin
      enable_in[3] = 1'b1; data_in[3] = DW'(w);
      settle();
      n_total++;
      if (ready_out[3] !== 1'b1) $display("FAIL bp_accept_%0d: got %b exp 1", w, ready_out[3]);
      else n_pass++;
      step();
    end
    data_in[3] = 64'd3;
    settle();
    for (int c = 0; c < 2; c++) begin
      n_total++;
      if (ready_out !== '0 || data_out !== 64'd1 || enable_out !== 1'b1)
        $display("FAIL bp_full: got rdy=%b d=%0d en=%b exp rdy=0 d=1 en=1",
                 ready_out, data_out, enable_out);
      else n_pass++;
      step();
    end
    ready_in = 1'b1;
    settle();
    n_total++;
    if (ready_out[3] !== 1'b0) $display("FAIL bp_first_pop_ready: got %b exp 0", ready_out[3]);
    else n_pass++;
    for (int w = 1; w <= 3; w++) begin
      n_total++;
      if (enable_out !== 1'b1 || data_out !== DW'(w))
        $display("FAIL bp_order_%0d: got en=%b d=%0d exp en=1 d=%0d", w, enable_out, data_out, w);
      else n_pass++;
      step();
      if (w == 2) enable_in[3] = 1'b0;
      settle();
    end
    n_total++;
    if (enable_out !== 1'b0) $display("FAIL bp_drain: got %b exp 0", enable_out);
    else n_pass++;
  endtask

  task automatic test_stream();
    int errs;
    errs = 0;
    col_tag = 4'd13; ready_in = 1'b1;
    enable_in[13] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      data_in[13] = DW'(k);
      settle();
      if (ready_out[13] !== 1'b1) errs++;
      if (k > 0 && (enable_out !== 1'b1 || data_out !== DW'(k - 1) || tag_out !== 4'd13)) errs++;
      step();
    end
    enable_in[13] = 1'b0;
    settle();
    n_total++;
    if (errs != 0) $display("FAIL stream_flow: got %0d bad cycles exp 0", errs);
    else n_pass++;
    n_total++;
    if (enable_out !== 1'b1 || data_out !== 64'd19)
      $display("FAIL stream_last: got en=%b d=%0d exp en=1 d=19", enable_out, data_out);
    else n_pass++;
    step();
    n_total++;
    if (enable_out !== 1'b0) $display("FAIL stream_drain: got %b exp 0", enable_out);
    else n_pass++;
  endtask

  task automatic test_tag_switch();
    ready_in = 1'b0; col_tag = 4'd2;
    enable_in[2] = 1'b1; data_in[2] = 64'h2;
    step();
    enable_in[2] = 1'b0;
    col_tag = 4'd7; enable_in[7] = 1'b1; data_in[7] = 64'h7;
    settle();
    n_total++;
    if (ready_out[7] !== 1'b1 || tag_out !== 4'd2)
      $display("FAIL tag_sw_accept: got rdy7=%b t=%0d exp rdy7=1 t=2", ready_out[7], tag_out);
    else n_pass++;
    step();
    enable_in[7] = 1'b0;
    settle();
    n_total++;
    if (data_out !== 64'h2 || tag_out !== 4'd2)
      $display("FAIL tag_sw_head: got d=%h t=%0d exp d=2 t=2", data_out, tag_out);
    else n_pass++;
    ready_in = 1'b1;
    step();
    n_total++;
    if (enable_out !== 1'b1 || data_out !== 64'h7 || tag_out !== 4'd7)
      $display("FAIL tag_sw_second: got en=%b d=%h t=%0d exp en=1 d=7 t=7",
               enable_out, data_out, tag_out);
    else n_pass++;
    step();
  endtask

  task automatic test_mismatch_dup();
    logic [0:NC-1] exp;
    col_tag = 4'd15; ready_in = 1'b0;
    enable_in = '1;
    for (int i = 0; i < NC; i++) data_in[i] = {$urandom, $urandom};
    settle();
    n_total++;
    if (ready_out !== '0) $display("FAIL nomatch_ready: got %b exp 0", ready_out);
    else n_pass++;
    step();
    n_total++;
    if (enable_out !== 1'b0) $display("FAIL nomatch_count: got en=%b exp 0", enable_out);
    else n_pass++;
    enable_in = '0;
    col_id[4] = 4'd6; col_id[9] = 4'd6; col_id[6] = 4'd14;
    col_tag = 4'd6; enable_in[4] = 1'b1; enable_in[9] = 1'b1;
    exp = '0; exp[4] = 1'b1;
    settle();
    n_total++;
    if (ready_out !== exp) $display("FAIL dup_ready: got %b exp %b", ready_out, exp);
    else n_pass++;
    step();
    enable_in = '0; ready_in = 1'b1;
    settle();
    n_total++;
    if (multi_match_err !== 1'b1 || data_out !== data_in[4])
      $display("FAIL dup_err_set: got err=%b d=%h exp err=1 d=%h", multi_match_err, data_out, data_in[4]);
    else n_pass++;
    default_ids();
    col_tag = 4'd0;
    step(); step(); step();
    n_total++;
    if (multi_match_err !== 1'b1) $display("FAIL dup_err_sticky: got %b exp 1", multi_match_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    ready_in = 1'b0; col_tag = 4'd0;
    enable_in[0] = 1'b1; data_in[0] = 64'hDEAD;
    step(); step();
    enable_in[0] = 1'b0;
    reset = 1'b1;
    step();
    n_total++;
    if (enable_out !== 1'b0 || multi_match_err !== 1'b0)
      $display("FAIL rst_mid: got en=%b err=%b exp en=0 err=0", enable_out, multi_match_err);
    else n_pass++;
    reset = 1'b0;
    col_tag = 4'd1; enable_in[1] = 1'b1; data_in[1] = 64'hBEEF_0001;
    step();
    enable_in[1] = 1'b0; ready_in = 1'b1;
    settle();
    n_total++;
    if (enable_out !== 1'b1 || data_out !== 64'hBEEF_0001 || tag_out !== 4'd1)
      $display("FAIL rst_first_push: got en=%b d=%h t=%0d exp en=1 d=beef0001 t=1",
               enable_out, data_out, tag_out);
    else n_pass++;
    step();
    n_total++;
    if (enable_out !== 1'b0) $display("FAIL rst_alone: got en=%b exp 0", enable_out);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    logic [0:NC-1] er;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NC; i++) begin
        col_id[i]  = TW'($urandom_range(0, 15));
        data_in[i] = {$urandom, $urandom};
      end
      enable_in = NC'($urandom);
      col_tag   = TW'($urandom_range(0, 15));
      ready_in  = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 63) == 0);
      settle();
      er = m_ready();
      if (ready_out !== er) errs++;
      if (enable_out !== (q.size() != 0)) errs++;
      if (q.size() != 0 && {data_out, tag_out} !== q[0]) errs++;
      if (multi_match_err !== m_err) errs++;
      if (errs == 1 && c < 400) begin
        $display("FAIL random_cycle_%0d: got rdy=%b en=%b d=%h t=%0d err=%b exp rdy=%b en=%b err=%b",
                 c, ready_out, enable_out, data_out, tag_out, multi_match_err,
                 er, (q.size() != 0), m_err);
        errs++;
      end
      step();
    end
    reset = 1'b0;
    n_total++;
    if (errs != 0) $display("FAIL random_model: got %0d mismatching cycles exp 0", errs);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_tag_switch();
    test_mismatch_dup();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
